// File: rtl/renkon_accum_multi_if.sv
// Beat and result bundle between the multiply-add tree, the accumulator and the pooling stage.
// Results are pulses with no handshake; the source side never sees backpressure.
interface renkon_accum_multi_if #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 64
);
    localparam int ABITS = $clog2(DEPTH);

    logic                      in_valid;
    logic                      first;
    logic                      last;
    logic [ABITS-1:0]          addr;
    logic [4:0]                qshift;
    logic [LANES*DWIDTH-1:0]   pixel_in;
    logic                      out_valid;
    logic [ABITS-1:0]          out_addr;
    logic [LANES*DWIDTH-1:0]   pixel_out;
    logic [LANES-1:0]          out_sat;
    logic                      ovf_sticky;

    modport master (
        output in_valid, first, last, addr, qshift, pixel_in,
        input  out_valid, out_addr, pixel_out, out_sat, ovf_sticky
    );

    modport slave (
        input  in_valid, first, last, addr, qshift, pixel_in,
        output out_valid, out_addr, pixel_out, out_sat, ovf_sticky
    );
endinterface

// File: rtl/renkon_accum_multi.sv
// Multi-lane saturating partial-sum accumulator with rounded, shifted, saturated output.
// A last beat at cycle T gives an out_valid pulse at T+2; one beat per cycle, no backpressure.
module renkon_accum_multi #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 64,
    parameter int GUARD  = 8
) (
    input  logic                clk,
    input  logic                rst,
    renkon_accum_multi_if.slave bus
);
    localparam int ABITS = $clog2(DEPTH);
    localparam int AW    = DWIDTH + GUARD;
    localparam int PW    = LANES * DWIDTH;
    localparam int SW    = LANES * AW;

    logic [SW-1:0]    mem [DEPTH];
    logic [SW-1:0]    rd_data;

    logic             p1_valid;
    logic             p1_first;
    logic             p1_last;
    logic [ABITS-1:0] p1_addr;
    logic [4:0]       p1_qshift;
    logic [PW-1:0]    p1_pix;

    logic             fwd_valid;
    logic [ABITS-1:0] fwd_addr;
    logic [SW-1:0]    fwd_sum;
    logic             fwd_hit;

    logic [4:0]       shamt;
    logic [SW-1:0]    sum_all;
    logic [PW-1:0]    res_all;
    logic [LANES-1:0] acc_clip;
    logic [LANES-1:0] out_clip;

    logic             out_valid_q;
    logic [ABITS-1:0] out_addr_q;
    logic [PW-1:0]    pixel_out_q;
    logic [LANES-1:0] out_sat_q;
    logic             ovf_q;

    // The RAM read for this beat was issued while the previous beat was still being written.
    assign fwd_hit = fwd_valid && (fwd_addr == p1_addr);
    assign shamt   = (int'(p1_qshift) >= AW) ? 5'(AW - 1) : p1_qshift;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DWIDTH-1:0]   pix;
        logic signed [AW-1:0]       old;
        logic signed [AW-1:0]       sum;
        logic signed [AW:0]         wide;
        logic signed [AW:0]         rnd;
        logic signed [AW:0]         rsum;
        logic signed [AW:0]         shifted;
        logic [AW-DWIDTH+1:0]       top;
        logic signed [DWIDTH-1:0]   res;
        logic                       a_clip;
        logic                       o_clip;

        always_comb begin
            pix    = p1_pix[k*DWIDTH +: DWIDTH];
            old    = fwd_hit ? fwd_sum[k*AW +: AW] : rd_data[k*AW +: AW];
            wide   = {old[AW-1], old} + {{(AW+1-DWIDTH){pix[DWIDTH-1]}}, pix};
            a_clip = 1'b0;
            if (p1_first) begin
                sum = {{GUARD{pix[DWIDTH-1]}}, pix};
            end else if (wide[AW] != wide[AW-1]) begin
                a_clip = 1'b1;
                sum    = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                sum = wide[AW-1:0];
            end

            rnd = '0;
            if (shamt != 5'd0) begin
                rnd = {{AW{1'b0}}, 1'b1} << (shamt - 5'd1);
            end
            rsum    = {sum[AW-1], sum} + rnd;
            shifted = rsum >>> shamt;
            top     = shifted[AW:DWIDTH-1];
            o_clip  = !((&top) || !(|top));
            if (o_clip) begin
                res = shifted[AW] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
            end else begin
                res = shifted[DWIDTH-1:0];
            end
        end

        assign sum_all[k*AW +: AW]         = sum;
        assign res_all[k*DWIDTH +: DWIDTH] = res;
        assign acc_clip[k]                 = a_clip;
        assign out_clip[k]                 = o_clip;
    end

    // Read-first: a same-edge write is not seen by the read, hence the forwarding path.
    always_ff @(posedge clk) begin
        if (p1_valid) begin
            mem[p1_addr] <= sum_all;
        end
        if (bus.in_valid) begin
            rd_data <= mem[bus.addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid    <= 1'b0;
            p1_first    <= 1'b0;
            p1_last     <= 1'b0;
            p1_addr     <= '0;
            p1_qshift   <= '0;
            p1_pix      <= '0;
            fwd_valid   <= 1'b0;
            fwd_addr    <= '0;
            fwd_sum     <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            pixel_out_q <= '0;
            out_sat_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            p1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p1_first  <= bus.first;
                p1_last   <= bus.last;
                p1_addr   <= bus.addr;
                p1_qshift <= bus.qshift;
                p1_pix    <= bus.pixel_in;
            end

            fwd_valid <= p1_valid;
            if (p1_valid) begin
                fwd_addr <= p1_addr;
                fwd_sum  <= sum_all;
            end

            out_valid_q <= p1_valid && p1_last;
            if (p1_valid && p1_last) begin
                out_addr_q  <= p1_addr;
                pixel_out_q <= res_all;
                out_sat_q   <= acc_clip | out_clip;
            end

            if (p1_valid && ((|acc_clip) || (p1_last && (|out_clip)))) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.pixel_out  = pixel_out_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.ovf_sticky = ovf_q;
endmodule

// File: tb/tb_renkon_accum_multi.sv
// Bench for renkon_accum_multi: fixed vectors, corner sequences and random beats against an
// unbounded-integer reference model; results are matched by due cycle at the falling edge.
module tb_renkon_accum_multi;
    localparam int DW = 16;
    localparam int LN = 8;
    localparam int DP = 64;
    localparam int GD = 8;
    localparam int AW = DW + GD;
    localparam int AB = $clog2(DP);
    localparam int PW = LN * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    renkon_accum_multi_if #(.DWIDTH(DW), .LANES(LN), .DEPTH(DP)) bus ();

    renkon_accum_multi #(.DWIDTH(DW), .LANES(LN), .DEPTH(DP), .GUARD(GD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            due;
        logic [AB-1:0] addr;
        logic [PW-1:0] pix;
        logic [LN-1:0] sat;
    } exp_t;

    typedef struct {
        bit f;
        bit l;
        int a;
        int q;
        int v;
        int ex;
        bit es;
    } vec_t;

    exp_t   exp_q[$];
    exp_t   ce;
    vec_t   tab[18];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    longint model_acc [LN][DP];
    bit     touched [DP];
    bit     model_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic longint satn(input longint x, input int n, output bit c);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (n - 1)) - 1;
        mn = -(longint'(1) <<< (n - 1));
        c  = 1'b0;
        if (x > mx) begin
            c = 1'b1;
            return mx;
        end
        if (x < mn) begin
            c = 1'b1;
            return mn;
        end
        return x;
    endfunction

    function automatic logic [PW-1:0] fill(input int v);
        logic [PW-1:0] p;
        for (int k = 0; k < LN; k++) p[k*DW +: DW] = DW'(v);
        return p;
    endfunction

    function automatic logic [PW-1:0] rnd_pix(input bit big);
        logic [PW-1:0] p;
        for (int k = 0; k < LN; k++)
            p[k*DW +: DW] = big ? DW'($urandom) : DW'($urandom_range(0, 400) - 200);
        return p;
    endfunction

    // Drives one valid beat, advances the model, and queues the expected result of a last beat.
    task automatic beat(input bit f, input bit l, input int a, input int q, input logic [PW-1:0] px,
                        input bit use_tab, input logic [PW-1:0] tab_pix, input logic [LN-1:0] tab_sat);
        exp_t          e;
        logic [PW-1:0] mp;
        logic [LN-1:0] ms;
        bit            ca;
        bit            co;
        longint        s;
        longint        r;
        int            sh;
        mp = '0;
        ms = '0;
        for (int k = 0; k < LN; k++) begin
            s = longint'($signed(px[k*DW +: DW]));
            if (!f) s = s + model_acc[k][a];
            s = satn(s, AW, ca);
            model_acc[k][a] = s;
            co = 1'b0;
            if (l) begin
                sh = (q >= AW) ? AW - 1 : q;
                r  = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
                r  = satn(r, DW, co);
                mp[k*DW +: DW] = r[DW-1:0];
                ms[k] = ca | co;
            end
            if (ca || co) model_ovf = 1'b1;
        end
        touched[a]   = 1'b1;
        bus.in_valid = 1'b1;
        bus.first    = f;
        bus.last     = l;
        bus.addr     = AB'(a);
        bus.qshift   = 5'(q);
        bus.pixel_in = px;
        if (l) begin
            e.due  = cyc + 2;
            e.addr = AB'(a);
            e.pix  = use_tab ? tab_pix : mp;
            e.sat  = use_tab ? tab_sat : ms;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.in_valid = 1'b0;
            bus.first    = 1'($urandom);
            bus.last     = 1'($urandom);
            bus.addr     = AB'($urandom);
            bus.qshift   = 5'($urandom);
            bus.pixel_in = rnd_pix(1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, PW'(bus.out_valid), PW'(0));
        chk({tag, "_pixel_out"}, bus.pixel_out, PW'(0));
        chk({tag, "_out_addr"}, PW'(bus.out_addr), PW'(0));
        chk({tag, "_out_sat"}, PW'(bus.out_sat), PW'(0));
        chk({tag, "_ovf_sticky"}, PW'(bus.ovf_sticky), PW'(0));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ce = exp_q.pop_front();
                chk("out_valid", PW'(bus.out_valid), PW'(1));
                chk("out_addr", PW'(bus.out_addr), PW'(ce.addr));
                chk("pixel_out", bus.pixel_out, ce.pix);
                chk("out_sat", PW'(bus.out_sat), PW'(ce.sat));
            end else begin
                chk("no_pulse", PW'(bus.out_valid), PW'(0));
            end
        end
    end

    initial begin
        logic [PW-1:0] lp;
        logic [PW-1:0] le;
        int            ra;
        int            rq;
        bit            rf;
        bit            rl;
        int            lane_exp [LN];

        tab[0]  = '{1, 0, 5, 0, 3, 0, 0};
        tab[1]  = '{0, 0, 5, 0, 4, 0, 0};
        tab[2]  = '{0, 1, 5, 0, -2, 5, 0};
        tab[3]  = '{1, 0, 0, 0, 1, 0, 0};
        tab[4]  = '{1, 0, 1, 0, 10, 0, 0};
        tab[5]  = '{0, 1, 0, 0, 1, 2, 0};
        tab[6]  = '{0, 1, 1, 0, 10, 20, 0};
        tab[7]  = '{1, 0, 7, 2, 5, 0, 0};
        tab[8]  = '{0, 1, 7, 2, 6, 3, 0};
        tab[9]  = '{1, 1, 7, 2, 11, 3, 0};
        tab[10] = '{1, 1, 8, 2, -11, -3, 0};
        tab[11] = '{1, 1, 9, 2, 10, 3, 0};
        tab[12] = '{1, 1, 10, 31, 1000, 0, 0};
        tab[13] = '{1, 1, 11, 31, -1000, 0, 0};
        tab[14] = '{1, 1, 12, 0, -32768, -32768, 0};
        tab[15] = '{0, 1, 12, 3, -32768, -8192, 0};
        tab[16] = '{1, 1, 20, 1, 7, 4, 0};
        tab[17] = '{1, 1, 21, 1, -7, -3, 0};
        lane_exp = '{-2, -1, -1, 0, 0, 1, 1, 2};

        model_ovf = 1'b0;
        for (int i = 0; i < DP; i++) touched[i] = 1'b0;
        rst = 1'b1;
        idle(1);
        chk_zero("reset");
        idle(1);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 18; i++)
            beat(tab[i].f, tab[i].l, tab[i].a, tab[i].q, fill(tab[i].v),
                 1'b1, fill(tab[i].ex), {LN{tab[i].es}});
        idle(3);
        chk("ovf_clean", PW'(bus.ovf_sticky), PW'(0));

        beat(1'b1, 1'b0, 13, 0, fill(30000), 1'b0, '0, '0);
        beat(1'b0, 1'b1, 13, 0, fill(30000), 1'b1, fill(32767), '1);
        idle(3);
        chk("ovf_outclip", PW'(bus.ovf_sticky), PW'(1));

        for (int i = 0; i < 300; i++)
            beat(i == 0, i == 299, 3, 0, fill(32767), i == 299, fill(32767), '1);
        for (int i = 0; i < 300; i++)
            beat(i == 0, i == 299, 4, 0, fill(-32768), i == 299, fill(-32768), '1);
        idle(3);
        chk("ovf_sat", PW'(bus.ovf_sticky), PW'(1));

        for (int k = 0; k < LN; k++) begin
            lp[k*DW +: DW] = DW'(k - 4);
            le[k*DW +: DW] = DW'(lane_exp[k]);
        end
        beat(1'b1, 1'b1, 30, 1, lp, 1'b1, le, '0);
        idle(3);

        // Reset one cycle after a last beat is accepted: its result must never appear.
        beat(1'b1, 1'b1, 9, 0, fill(6), 1'b1, fill(6), '0);
        rst = 1'b1;
        exp_q.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < DP; i++) touched[i] = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        chk_zero("in_reset");
        idle(2);
        chk_zero("hold_reset");
        rst = 1'b0;
        idle(2);
        chk_zero("post_reset");
        beat(1'b1, 1'b1, 9, 0, fill(7), 1'b1, fill(7), '0);
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                idle(1);
            end else begin
                ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DP - 1)) : int'($urandom_range(0, 3));
                rf = !touched[ra] || ($urandom_range(0, 6) == 0);
                rl = ($urandom_range(0, 3) == 0);
                rq = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
                beat(rf, rl, ra, rq, rnd_pix($urandom_range(0, 3) == 0), 1'b0, '0, '0);
            end
        end
        idle(4);
        chk("ovf_random", PW'(bus.ovf_sticky), PW'(model_ovf));
        chk("drained", PW'(exp_q.size()), PW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
